dffs_vector_sweeper: RTL and testbench

Self-checking stimulus stage that sits directly upstream of a DFFS-type cell (D flip-flop, active-low set SN, outputs Q/QN). On START it forces the cell to a known state and walks all 8 {D,SN,CK} input combinations in binary order. It drives the cell's D/SN/CK pins as registered data and samples Q/QN back after a settle window. It compares each sample against an internal cell model and reports per-vector failures, an error count and pass/fail. It replaces hand-written per-cell truth-table benches and can be instantiated in silicon or simulation harnesses.

---
 rtl/dffs_vector_sweeper.sv | 203 ++++++++++++++++++++
 tb/tb_dffs_vector_sweeper.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dffs_vector_sweeper.sv
// -----------------------------------------------------------------------------
// dffs_vector_sweeper
//
// Stimulus/checker stage for a DFFS cell (D flip-flop with active-low set SN,
// outputs Q/QN). A START request in idle first forces the cell set for
// HOLD_CYCLES cycles. It then applies the eight {D,SN,CK} combinations in
// binary order, holding each for HOLD_CYCLES cycles. In the last hold cycle of
// each vector, Q/QN from the cell are compared against an internal cell model.
//
// Parameters
//   HOLD_CYCLES : cycles each vector (and the init phase) is held, 2..255
//
// Ports
//   CK       in   system clock, everything on the rising edge
//   RST      in   synchronous active-high reset
//   START    in   one-cycle sweep request, honoured only when idle
//   Q_IN     in   Q from the cell under test
//   QN_IN    in   QN from the cell under test
//   D_OUT    out  cell D pin
//   SN_OUT   out  cell SN pin (active-low set)
//   CK_OUT   out  cell CK pin (a data bit here, not a clock)
//   BUSY     out  sweep in progress
//   DONE     out  one-cycle pulse at sweep end
//   PASS     out  last completed sweep had no mismatches
//   ERR_CNT  out  mismatching vectors in the last/current sweep (0..8)
//   FAIL_VEC out  bit i set when vector i mismatched
//   VEC_IDX  out  index of the vector currently applied
// -----------------------------------------------------------------------------
module dffs_vector_sweeper #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic       Q_IN,
  input  logic       QN_IN,
  output logic       D_OUT,
  output logic       SN_OUT,
  output logic       CK_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [7:0] FAIL_VEC,
  output logic [2:0] VEC_IDX
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_APPLY  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  // Pin order inside pins_q is {D, SN, CK}; it equals the vector index.
  localparam logic [2:0] PINS_INIT = 3'b000;
  localparam logic [2:0] PINS_REST = 3'b010;

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [2:0] vec_q,   vec_d;
  logic [2:0] pins_q,  pins_d;
  logic       model_q, model_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       pass_q,  pass_d;
  logic [3:0] err_q,   err_d;
  logic [7:0] fail_q,  fail_d;
  logic       mismatch_s;

  // Cell model: set dominates, otherwise capture D on a CK rise relative to
  // the previously applied vector, otherwise hold.
  function automatic logic next_model(input logic [2:0] pins_new,
                                      input logic       ck_prev,
                                      input logic       q_prev);
    logic q;
    if (pins_new[1] == 1'b0) begin
      q = 1'b1;
    end else if ((ck_prev == 1'b0) && (pins_new[0] == 1'b1)) begin
      q = pins_new[2];
    end else begin
      q = q_prev;
    end
    return q;
  endfunction

  // Case-equality so that an X or Z from the cell counts as a mismatch.
  assign mismatch_s = !((Q_IN === model_q) && (QN_IN === ~model_q));

  // Sweep sequencing, model update and result accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    pins_d  = pins_q;
    model_d = model_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_INIT;
          cnt_d   = 8'd0;
          vec_d   = 3'd0;
          pins_d  = PINS_INIT;
          model_d = 1'b1;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 4'd0;
          fail_d  = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_APPLY;
          cnt_d   = 8'd0;
          vec_d   = 3'd0;
          pins_d  = 3'd0;
          model_d = next_model(3'd0, pins_q[0], model_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_APPLY: begin
        if (cnt_q == HOLD_LAST) begin
          if (mismatch_s) begin
            fail_d[vec_q] = 1'b1;
            err_d         = err_q + 4'd1;
          end else begin
            err_d = err_q;
          end
          cnt_d = 8'd0;
          if (vec_q == 3'd7) begin
            // PASS must include the verdict of this final sample.
            state_d = ST_FINISH;
            vec_d   = 3'd0;
            pins_d  = PINS_REST;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 4'd0);
          end else begin
            state_d = ST_APPLY;
            vec_d   = vec_q + 3'd1;
            pins_d  = vec_q + 3'd1;
            model_d = next_model(vec_q + 3'd1, pins_q[0], model_q);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_FINISH: begin
        // START during the DONE cycle is deliberately not accepted.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; an abort gives no DONE pulse.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      vec_q   <= 3'd0;
      pins_q  <= PINS_REST;
      model_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fail_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      pins_q  <= pins_d;
      model_q <= model_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign D_OUT    = pins_q[2];
  assign SN_OUT   = pins_q[1];
  assign CK_OUT   = pins_q[0];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fail_q;
  assign VEC_IDX  = vec_q;

endmodule

// File: tb/tb_dffs_vector_sweeper.sv
// -----------------------------------------------------------------------------
// Testbench for dffs_vector_sweeper. Cell behaviours (good, stuck Q, no set,
// QN tied low, random per-vector Q corruption) are emulated in the bench.
// Expected verdicts come from a truth-table model of the DFFS cell.
// -----------------------------------------------------------------------------
module tb_dffs_vector_sweeper;

  localparam int H  = 4;
  localparam int H2 = 2;

  logic       CK = 1'b0;
  logic       RST, START, Q_IN, QN_IN;
  logic       D_OUT, SN_OUT, CK_OUT, BUSY, DONE, PASS;
  logic [3:0] ERR_CNT;
  logic [7:0] FAIL_VEC;
  logic [2:0] VEC_IDX;

  logic       START2, Q_IN2, QN_IN2;
  logic       D_OUT2, SN_OUT2, CK_OUT2, BUSY2, DONE2, PASS2;
  logic [3:0] ERR_CNT2;
  logic [7:0] FAIL_VEC2;
  logic [2:0] VEC_IDX2;

  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         chk_cnt  = 0;

  int         mode;
  logic [7:0] mask;
  logic       cell_clr;
  logic       cell_q, noset_q, cell2_q;

  always #5 CK = ~CK;

  dffs_vector_sweeper #(.HOLD_CYCLES(H)) dut (
    .CK(CK), .RST(RST), .START(START), .Q_IN(Q_IN), .QN_IN(QN_IN),
    .D_OUT(D_OUT), .SN_OUT(SN_OUT), .CK_OUT(CK_OUT), .BUSY(BUSY),
    .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT), .FAIL_VEC(FAIL_VEC),
    .VEC_IDX(VEC_IDX)
  );

  dffs_vector_sweeper #(.HOLD_CYCLES(H2)) dut2 (
    .CK(CK), .RST(RST), .START(START2), .Q_IN(Q_IN2), .QN_IN(QN_IN2),
    .D_OUT(D_OUT2), .SN_OUT(SN_OUT2), .CK_OUT(CK_OUT2), .BUSY(BUSY2),
    .DONE(DONE2), .PASS(PASS2), .ERR_CNT(ERR_CNT2), .FAIL_VEC(FAIL_VEC2),
    .VEC_IDX(VEC_IDX2)
  );

  // Good DFFS cell behind the first sweeper.
  always @(posedge CK_OUT or negedge SN_OUT) begin
    if (!SN_OUT) cell_q <= 1'b1;
    else         cell_q <= D_OUT;
  end

  // Faulty cell with the set input ignored; cleared by the bench.
  always @(posedge CK_OUT or posedge cell_clr) begin
    if (cell_clr) noset_q <= 1'b0;
    else          noset_q <= D_OUT;
  end

  // Good DFFS cell behind the second sweeper.
  always @(posedge CK_OUT2 or negedge SN_OUT2) begin
    if (!SN_OUT2) cell2_q <= 1'b1;
    else          cell2_q <= D_OUT2;
  end

  assign Q_IN2  = cell2_q;
  assign QN_IN2 = ~cell2_q;

  // Selects which cell behaviour feeds the first sweeper.
  always_comb begin
    Q_IN  = cell_q;
    QN_IN = ~cell_q;
    case (mode)
      1: begin Q_IN = 1'b1;                    QN_IN = 1'b0;     end
      2: begin Q_IN = noset_q;                 QN_IN = ~noset_q; end
      3: begin Q_IN = cell_q;                  QN_IN = 1'b0;     end
      4: begin Q_IN = cell_q ^ mask[VEC_IDX];  QN_IN = ~cell_q;  end
      default: begin Q_IN = cell_q; QN_IN = ~cell_q; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Truth-table reference: expected Q after each of the 8 vectors.
  function automatic logic [7:0] ref_q();
    logic [7:0] e;
    logic       q, prev_ck;
    logic [2:0] v;
    q = 1'b1;        // init phase forces the cell set
    prev_ck = 1'b0;
    e = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if (!v[1])                q = 1'b1;
      else if (!prev_ck && v[0]) q = v[2];
      e[i] = q;
      prev_ck = v[0];
    end
    return e;
  endfunction

  // Expected FAIL_VEC for a given cell behaviour.
  function automatic logic [7:0] ref_fail(input int m, input logic [7:0] msk);
    logic [7:0] e, f;
    logic       nq, prev_ck, oq, oqn;
    logic [2:0] v;
    e = ref_q();
    f = 8'h00;
    nq = 1'b0;
    prev_ck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if (!prev_ck && v[0]) nq = v[2];
      prev_ck = v[0];
      case (m)
        1: begin oq = 1'b1;          oqn = 1'b0;   end
        2: begin oq = nq;            oqn = ~nq;    end
        3: begin oq = e[i];          oqn = 1'b0;   end
        4: begin oq = e[i] ^ msk[i]; oqn = ~e[i];  end
        default: begin oq = e[i];    oqn = ~e[i];  end
      endcase
      f[i] = (oq != e[i]) || (oqn != ~e[i]);
    end
    return f;
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_d"},    D_OUT,    1'b0);
    check({pfx, "_sn"},   SN_OUT,   1'b1);
    check({pfx, "_ck"},   CK_OUT,   1'b0);
    check({pfx, "_busy"}, BUSY,     1'b0);
    check({pfx, "_done"}, DONE,     1'b0);
    check({pfx, "_pass"}, PASS,     1'b0);
    check({pfx, "_err"},  ERR_CNT,  4'd0);
    check({pfx, "_fail"}, FAIL_VEC, 8'h00);
    check({pfx, "_idx"},  VEC_IDX,  3'd0);
  endtask

  // One full sweep on the first sweeper, checking pins every cycle.
  task automatic run_sweep(input int m, input logic [7:0] msk, input bit extra_start);
    logic [7:0] exp_fail;
    logic [2:0] exp_pins;
    int         n, p;
    mode = m;
    mask = msk;
    exp_fail = ref_fail(m, msk);
    cell_clr = 1'b1;
    #1 cell_clr = 1'b0;
    @(posedge CK); #1;
    START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
    n = 1;
    check("busy_on", BUSY, 1'b1);
    while (!DONE && n < 100) begin
      p = n - 1;
      exp_pins = (p < H) ? 3'b000 : 3'((p - H) / H);
      check("pins", {D_OUT, SN_OUT, CK_OUT}, exp_pins);
      check("vec_idx", VEC_IDX, (p < H) ? 3'd0 : exp_pins);
      check("busy", BUSY, 1'b1);
      START = (extra_start && (n == 5 || n == 20)) ? 1'b1 : 1'b0;
      @(posedge CK); #1;
      n++;
    end
    START = 1'b0;
    check("sweep_len", n + 1, 9 * H + 2);
    check("done", DONE, 1'b1);
    check("busy_end", BUSY, 1'b0);
    check("fail_vec", FAIL_VEC, exp_fail);
    check("err_cnt", ERR_CNT, 4'($countones(exp_fail)));
    check("pass", PASS, (exp_fail == 8'h00));
    check("pins_rest", {D_OUT, SN_OUT, CK_OUT}, 3'b010);
    if (extra_start) START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
    check("done_pulse", DONE, 1'b0);
    check("no_restart", BUSY, 1'b0);
    check("fail_hold", FAIL_VEC, exp_fail);
    check("pass_hold", PASS, (exp_fail == 8'h00));
    @(posedge CK); #1;
    check("idle_busy", BUSY, 1'b0);
  endtask

  initial begin
    int n, dones;
    RST = 1'b1; START = 1'b0; START2 = 1'b0;
    mode = 0; mask = 8'h00; cell_clr = 1'b0;
    repeat (3) @(posedge CK);
    #1 RST = 1'b0;
    check_reset_vals("rst");

    // Directed cell behaviours; the good one also sees stray STARTs.
    run_sweep(0, 8'h00, 1'b1);
    run_sweep(1, 8'h00, 1'b0);
    run_sweep(2, 8'h00, 1'b0);
    run_sweep(3, 8'h00, 1'b0);

    // Abort mid-sweep after some mismatches have been logged.
    mode = 4; mask = 8'hFF;
    @(posedge CK); #1 START = 1'b1;
    @(posedge CK); #1 START = 1'b0;
    repeat (14) @(posedge CK);
    #1;
    check("pre_abort_err", ERR_CNT, 4'd2);
    RST = 1'b1;
    @(posedge CK); #1 RST = 1'b0;
    check_reset_vals("abort");
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge CK); #1;
      if (DONE) dones++;
    end
    check("abort_no_done", dones, 0);
    run_sweep(0, 8'h00, 1'b0);

    // RST and START together: reset wins.
    RST = 1'b1; START = 1'b1;
    @(posedge CK); #1;
    RST = 1'b0; START = 1'b0;
    check("rst_start_busy", BUSY, 1'b0);
    @(posedge CK); #1;
    check("rst_start_idle", BUSY, 1'b0);

    // Randomized cell behaviours.
    for (int k = 0; k < 6; k++) begin
      run_sweep(int'($urandom_range(0, 4)), 8'($urandom), 1'b0);
    end

    // Short hold time on the second sweeper.
    @(posedge CK); #1 START2 = 1'b1;
    @(posedge CK); #1 START2 = 1'b0;
    n = 1;
    while (!DONE2 && n < 100) begin
      @(posedge CK); #1;
      n++;
    end
    check("h2_len", n + 1, 9 * H2 + 2);
    check("h2_pass", PASS2, 1'b1);
    check("h2_err", ERR_CNT2, 4'd0);
    check("h2_fail", FAIL_VEC2, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
